// File: rtl/si571_pkg.sv
// Shared constants, FSM state codes and helpers for the Si571 reference generator.
package si571_pkg;

    localparam int          ACC_W_DEF = 32;
    localparam logic [31:0] DEF_FTW   = 32'h147AE148;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Word must be non-zero and below half-scale so the MSB still toggles.
    function automatic logic ftw_valid(input logic [63:0] ftw, input int w);
        return (ftw != 64'd0) && (((ftw >> (w - 1)) & 64'd1) == 64'd0);
    endfunction

endpackage

// File: rtl/si571_ref_gen_if.sv
// Control/status bundle between the reference generator and its host.
interface si571_ref_gen_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic             cfg_en_i;
    logic [ACC_W-1:0] ftw_i;
    logic             ftw_wr_i;
    logic             ftw_ack_o;
    logic             ftw_err_o;
    logic             ref_o;
    logic             ref_sync_o;
    logic             ref_ok_o;
    logic [CNT_W-1:0] edge_cnt_o;

    modport slave (
        input  cfg_en_i, ftw_i, ftw_wr_i,
        output ftw_ack_o, ftw_err_o, ref_o, ref_sync_o, ref_ok_o, edge_cnt_o
    );

    modport master (
        output cfg_en_i, ftw_i, ftw_wr_i,
        input  ftw_ack_o, ftw_err_o, ref_o, ref_sync_o, ref_ok_o, edge_cnt_o
    );
endinterface

// File: rtl/si571_ref_gen_nco_phase_acc.sv
// Phase accumulator: clear/step control, carry-out and MSB rising-edge look-ahead.
module nco_phase_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [ACC_W-1:0] ftw_i,
    output logic             msb_o,
    output logic             wrap_o,
    output logic             rise_o
);
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             carry;

    always_comb begin
        {carry, sum} = {1'b0, acc_q} + {1'b0, ftw_i};
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (step_i) begin
            acc_d = sum;
        end
    end

    assign msb_o  = acc_q[ACC_W-1];
    assign wrap_o = step_i & carry;
    // Asserted when the next registered MSB goes 0->1.
    assign rise_o = ~acc_q[ACC_W-1] & acc_d[ACC_W-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/si571_ref_gen.sv
// NCO square-wave reference with glitch-free start/stop, FTW update and settle flag.
module si571_ref_gen
    import si571_pkg::*;
#(
    parameter int               ACC_W       = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(DEF_FTW),
    parameter int               SETTLE_PER  = 16,
    parameter int               CNT_W       = 16
) (
    input logic clk_i,
    input logic rstn_i,
    si571_ref_gen_if.slave bus
);
    logic [1:0]       rs_q;
    logic             rst_n;
    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] active_q, active_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [15:0]      settle_q, settle_d;
    logic             msb, wrap, rise;
    logic             clr, step, apply, wr_valid;

    // Reset asserts immediately, releases two clocks later.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rs_q <= 2'b00;
        end else begin
            rs_q <= {rs_q[0], 1'b1};
        end
    end
    assign rst_n = rs_q[1];

    nco_phase_acc #(.ACC_W(ACC_W)) u_nco (
        .clk_i  (clk_i),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .step_i (step),
        .ftw_i  (active_q),
        .msb_o  (msb),
        .wrap_o (wrap),
        .rise_o (rise)
    );

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        step    = 1'b0;
        apply   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (bus.cfg_en_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                clr     = 1'b1;
                apply   = pending_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                step  = 1'b1;
                apply = pending_q & wrap;
                if (!bus.cfg_en_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                step = 1'b1;
                // Stop only once the output is, or is about to be, low.
                if (!msb || wrap) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_valid  = bus.ftw_wr_i & ftw_valid(64'(bus.ftw_i), ACC_W);
        active_d  = apply ? shadow_q : active_q;
        shadow_d  = wr_valid ? bus.ftw_i : shadow_q;
        pending_d = wr_valid | (pending_q & ~apply);
        err_d     = bus.ftw_wr_i & ~wr_valid;
        sync_d    = rise;
        edge_d    = edge_q + CNT_W'(rise);
        settle_d  = settle_q;
        if (state_q == ST_ARM || apply) begin
            settle_d = '0;
        end else if (state_q == ST_RUN && rise
                     && settle_q != 16'(SETTLE_PER)) begin
            settle_d = settle_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            active_q  <= DEFAULT_FTW;
            shadow_q  <= DEFAULT_FTW;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            sync_q    <= 1'b0;
            edge_q    <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            settle_q  <= settle_d;
        end
    end

    assign bus.ftw_ack_o  = apply;
    assign bus.ftw_err_o  = err_q;
    assign bus.ref_o      = msb;
    assign bus.ref_sync_o = sync_q;
    assign bus.ref_ok_o   = (state_q == ST_RUN) && (settle_q == 16'(SETTLE_PER));
    assign bus.edge_cnt_o = edge_q;
endmodule

// File: doc/si571_ref_gen.md
Name: si571_ref_gen

Overview:
- Transmit-side counterpart of the Si571 PLL lock logic: synthesises the square-wave reference (`ref_o`) that the PLL compares against.
- Derived from `clk_i` by a phase-accumulator NCO.
- Glitch-free start/stop and a runtime frequency-word update handshake.
- Reports a settled/valid flag once the output has run stably for a programmable number of periods.

Parameters:
- ACC_W, 32, phase accumulator width (bits).
- DEFAULT_FTW, 32'h147AE148, reset frequency tuning word (10 MHz at 125 MHz `clk_i`).
- SETTLE_PER, 16, rising edges required in RUN before `ref_ok_o` asserts (1..65535).
- CNT_W, 16, width of the rising-edge counter output.

Ports:
- clk_i  in  1  system clock; the only clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_en_i  in  1  level enable for reference generation.
- ftw_i  in  ACC_W  new tuning word.
- ftw_wr_i  in  1  one-cycle write strobe for `ftw_i`.
- ftw_ack_o  out  1  one-cycle pulse when a written word takes effect.
- ftw_err_o  out  1  one-cycle pulse when a write is rejected.
- ref_o  out  1  generated reference (accumulator MSB, registered).
- ref_sync_o  out  1  one-cycle pulse in the cycle `ref_o` goes 0->1.
- ref_ok_o  out  1  output settled and valid.
- edge_cnt_o  out  CNT_W  free-running count of `ref_o` rising edges; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert internally) values:
  - state=IDLE, acc=0, ftw_active=ftw_shadow=DEFAULT_FTW, pending=0.
  - All outputs 0, edge_cnt_o=0.
- States:
  - IDLE: acc held at 0, `ref_o`=0. `cfg_en_i`=1 -> ARM.
  - ARM (1 cycle): acc<=0; if pending, ftw_active<=ftw_shadow, `ftw_ack_o` pulses, pending<=0. Settle counter cleared. -> RUN.
  - RUN: each cycle acc<=acc+ftw_active (mod 2^ACC_W), `ref_o`=acc[ACC_W-1]. `cfg_en_i`=0 -> DRAIN.
  - DRAIN: accumulation continues. On the first cycle where the next acc MSB is 0: acc<=0, -> IDLE. If `ref_o` is already 0, this happens on the next cycle. No runt high pulse is ever emitted. `cfg_en_i` changes during DRAIN are ignored until IDLE is reached; if it is still 1 in IDLE, go to ARM the following cycle.
- Latency: `cfg_en_i` rise -> first `ref_o` high occurs at or after cycle 3 (IDLE sample, ARM, RUN accumulate).
- Rising edge:
  - `ref_sync_o`=1 exactly in cycles where `ref_o` transitions 0->1.
  - `edge_cnt_o` increments in the same cycle. It is not cleared by enable changes, only by reset.
- Frequency write, any state:
  - Accepted when `ftw_i`!=0 and `ftw_i`[ACC_W-1]==0: ftw_shadow<=`ftw_i`, pending<=1.
  - Otherwise rejected: shadow and pending unchanged, `ftw_err_o` pulses next cycle.
- Apply:
  - In RUN, pending is applied only on a wrap cycle (carry out of acc+ftw_active).
  - Effect: ftw_active<=ftw_shadow, pending<=0, `ftw_ack_o`=1 for that cycle, settle counter cleared, `ref_ok_o`<=0.
  - In IDLE/DRAIN the word stays pending until ARM.
- Write while pending: shadow overwritten; exactly one ack is issued, for the last word.
- Write in the same cycle as apply: apply uses the old shadow and acks it; the new word becomes shadow with pending=1.
- Settle:
  - The settle counter counts rising edges in RUN, saturating at SETTLE_PER.
  - `ref_ok_o`=1 when counter==SETTLE_PER and state==RUN.
  - Leaving RUN clears `ref_ok_o` in the same cycle as the state change.
- Reset mid-operation: immediate return to reset values, including loss of any pending word.

Decomposition:
- Shared package (`si571_pkg`): ACC_W default, DEFAULT_FTW, state enumeration (IDLE, ARM, RUN, DRAIN), FTW validity check function.
- One sub-module, `nco_phase_acc`:
  - Contains the accumulator register, carry-out and MSB-edge detect.
  - Inputs: clear and step enable.
  - Outputs: msb, wrap, rise.
- Control FSM, shadow/pending logic and settle counter live in `si571_ref_gen`.

Test Plan:
- Reset, FTW=2^30 written and enabled -> ack in ARM; `ref_o` period 4 cycles (2 high/2 low); `ref_sync_o` every 4 cycles; `ref_ok_o`=1 after the 16th rising edge.
- DEFAULT_FTW, enabled for 12500 cycles -> `edge_cnt_o`=1000 ±1; duty 50% ±1 cycle per period.
- RUN at FTW=2^30, write 2^29 mid-period -> `ftw_ack_o` only on the wrap cycle; period becomes 8 cycles; `ref_ok_o` drops and re-asserts after 16 new edges.
- Drop `cfg_en_i` while `ref_o`=1 at FTW=2^28 -> high phase completes its full 8 cycles, then IDLE with `ref_o`=0; re-enable during DRAIN -> ARM one cycle after IDLE.
- Write `ftw_i`=0, then 32'h80000000 -> two `ftw_err_o` pulses; ftw_active unchanged; no ack.
- Assert `rstn_i`=0 mid-RUN with a pending write -> all outputs 0 asynchronously; after release, enable -> runs at DEFAULT_FTW with no ack.
